// File: rtl/mm2_mem_resp.sv
// MM2-stage memory response unit: waits for the data-bus response of the MM1
// access, aligns/extends load data, and registers the MM2->WB payload.
module mm2_mem_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_mm_re,
  input  logic        in_mm_we,
  input  logic [1:0]  in_access_sz,
  input  logic        in_load_unsigned,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_exe_out,
  input  logic [4:0]  in_reg_d,
  input  logic        in_reg_d_wen,
  input  logic [31:0] in_pc,
  input  logic        in_excp,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  input  logic        wb_allowin,
  output logic        mm2_allowin,
  output logic        wb_valid,
  output logic        wb_excp,
  output logic [4:0]  wb_reg_d,
  output logic        wb_reg_d_wen,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_pc,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg_d,
  output logic [31:0] fwd_data,
  output logic        fwd_stall
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_GOT    = 2'b10,
    S_CANCEL = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;

  logic                wb_valid_q, wb_valid_d;
  logic                wb_excp_q, wb_excp_d;
  logic [4:0]          wb_reg_d_q, wb_reg_d_d;
  logic                wb_reg_d_wen_q, wb_reg_d_wen_d;
  logic [DATA_W-1:0]   wb_wdata_q, wb_wdata_d;
  logic [31:0]         wb_pc_q, wb_pc_d;

  logic                need_mem;
  logic                st_got;
  logic                st_cancel;
  logic                ready_go;
  logic                handoff;
  logic [DATA_W-1:0]   resp;
  logic [DATA_W-1:0]   wdata;
  logic                reg_wen;

  // Byte/half/word selection with sign or zero extension.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] data,
    input logic [1:0]        sz,
    input logic [1:0]        lo,
    input logic              uns
  );
    logic [DATA_W-1:0]   shifted;
    logic signed [7:0]   b;
    logic signed [15:0]  h;
    logic [DATA_W-1:0]   r;
    shifted = data >> {lo, 3'b000};
    b       = signed'(shifted[7:0]);
    h       = lo[1] ? signed'(data[31:16]) : signed'(data[15:0]);
    unique case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = data;
    endcase
    return r;
  endfunction

  assign need_mem  = in_valid & (in_mm_re | in_mm_we) & ~in_excp;
  assign st_got    = (state_q == S_GOT);
  assign st_cancel = (state_q == S_CANCEL);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; IDLE and WAIT behave alike since a fresh need_mem
  // instruction in IDLE is already waiting on its response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_WAIT: begin
        if (flush) begin
          state_d = (need_mem & ~data_ok) ? S_CANCEL : S_IDLE;
        end else if (need_mem & data_ok & ~wb_allowin) begin
          state_d = S_GOT;
        end else if (need_mem & ~data_ok) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GOT: begin
        if (flush | handoff) begin
          state_d = S_IDLE;
        end
      end
      S_CANCEL: begin
        if (data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_go    = ~need_mem | st_got | (data_ok & ~st_cancel);
    handoff     = in_valid & ready_go & wb_allowin;
    mm2_allowin = (~in_valid | (ready_go & wb_allowin)) & ~st_cancel;
    resp        = st_got ? buf_data_q : rdata;
    wdata       = (in_mm_re & ~in_excp)
                  ? load_extract(resp, in_access_sz, in_addr_lo, in_load_unsigned)
                  : in_exe_out;
    reg_wen     = in_reg_d_wen & ~in_excp & ~in_mm_we;
    fwd_valid   = in_valid & in_reg_d_wen & ~in_excp;
    fwd_reg_d   = in_reg_d;
    fwd_data    = wdata;
    fwd_stall   = fwd_valid & in_mm_re & ~ready_go;
  end

  // Response capture when WB cannot take the load in its data_ok cycle.
  always_comb begin
    buf_data_d = buf_data_q;
    if ((state_d == S_GOT) && !st_got) begin
      buf_data_d = rdata;
    end
  end

  always_comb begin
    wb_valid_d     = wb_valid_q;
    wb_excp_d      = wb_excp_q;
    wb_reg_d_d     = wb_reg_d_q;
    wb_reg_d_wen_d = wb_reg_d_wen_q;
    wb_wdata_d     = wb_wdata_q;
    wb_pc_d        = wb_pc_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (handoff) begin
      wb_valid_d     = 1'b1;
      wb_excp_d      = in_excp;
      wb_reg_d_d     = in_reg_d;
      wb_reg_d_wen_d = reg_wen;
      wb_wdata_d     = wdata;
      wb_pc_d        = in_pc;
    end else if (wb_allowin) begin
      wb_valid_d = 1'b0;
    end
  end

  // MM2 -> WB boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_excp_q      <= 1'b0;
      wb_reg_d_q     <= '0;
      wb_reg_d_wen_q <= 1'b0;
      wb_wdata_q     <= '0;
      wb_pc_q        <= '0;
    end else begin
      buf_data_q     <= buf_data_d;
      wb_valid_q     <= wb_valid_d;
      wb_excp_q      <= wb_excp_d;
      wb_reg_d_q     <= wb_reg_d_d;
      wb_reg_d_wen_q <= wb_reg_d_wen_d;
      wb_wdata_q     <= wb_wdata_d;
      wb_pc_q        <= wb_pc_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_excp      = wb_excp_q;
  assign wb_reg_d     = wb_reg_d_q;
  assign wb_reg_d_wen = wb_reg_d_wen_q;
  assign wb_wdata     = wb_wdata_q;
  assign wb_pc        = wb_pc_q;

endmodule

// File: doc/mm2_mem_resp.md
# mm2_mem_resp

MM2-stage memory response unit. It consumes the MM1→MM2 pipeline register outputs and waits for the data-bus response of the load or store issued in MM1. It aligns and extends load data, then registers the MM2→WB payload. It generates the MM2 `allowin` backpressure and the MM2 forwarding and stall hints for decode.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: pipeline flush (exception/ertn commit); kills the MM2 instruction this cycle.
- `in_valid` in 1: MM2 holds an instruction (nonzero PC from MM1→MM2 register, qualified upstream). Held stable while `mm2_allowin`=0.
- `in_mm_re`, `in_mm_we` in 1 each: load / store issued in MM1.
- `in_access_sz` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `in_load_unsigned` in 1: zero-extend (ld.bu/ld.hu).
- `in_addr_lo` in 2: mm_addr[1:0].
- `in_exe_out` in 32: ALU/CSR result for non-loads.
- `in_reg_d` in 5, `in_reg_d_wen` in 1, `in_pc` in 32.
- `in_excp` in 1: any exception flag set; no bus request was issued.
- `data_ok` in 1: bus response strobe, one per issued request.
- `rdata` in 32: load data, valid with `data_ok`.
- `wb_allowin` in 1: WB can accept.
- `mm2_allowin` out 1.
- `wb_valid` out 1, `wb_excp` out 1, `wb_reg_d` out 5, `wb_reg_d_wen` out 1, `wb_wdata` out 32, `wb_pc` out 32: registered.
- `fwd_valid` out 1, `fwd_reg_d` out 5, `fwd_data` out 32, `fwd_stall` out 1: combinational.

## Operation
- `need_mem` = `in_valid` & (`in_mm_re`|`in_mm_we`) & !`in_excp`.
- FSM states:
  - IDLE: no response pending, or the MM2 instruction needs none.
  - WAIT: `need_mem` and `data_ok` not yet received.
  - GOT: response captured in `buf_data`, WB not yet accepted.
  - CANCEL: flushed while the response was outstanding.
- Transitions:
  - IDLE/WAIT →GOT on `data_ok` & !(`ready_go`&`wb_allowin`).
  - →IDLE on handoff.
  - WAIT+`flush` with no `data_ok` →CANCEL.
  - CANCEL→IDLE on `data_ok` (data discarded).
  - `flush` in GOT →IDLE.
- A `need_mem` instruction arriving in IDLE is WAIT logically. The FSM is in WAIT whenever `need_mem` & !GOT & !CANCEL.
- `ready_go` = !`need_mem` | GOT | (`data_ok` & state≠CANCEL).
- `mm2_allowin` = (!`in_valid` | (`ready_go` & `wb_allowin`)) & state≠CANCEL.
- `resp` = GOT ? `buf_data` : `rdata`. `rdata` is only sampled when `data_ok`=1.
- Load extraction:
  - byte: `resp` >> (8·`in_addr_lo`), low 8 bits.
  - half: `in_addr_lo`[1] selects the upper or lower 16 bits.
  - word: `resp` unchanged.
  - Sign-extend unless `in_load_unsigned`.
  - Misaligned addresses never reach here (ALE sets `in_excp`).
- WB data: `wdata` = `in_mm_re` & !`in_excp` ? extracted : `in_exe_out`.
- WB register-write enable: `in_reg_d_wen` & !`in_excp` & !`in_mm_we`.
- WB register:
  - If `flush`: `wb_valid`←0.
  - Else if `in_valid`&`ready_go`&`wb_allowin`: load all `wb_*` (`wb_excp`←`in_excp`, `wb_valid`←1).
  - Else if `wb_allowin`: `wb_valid`←0.
  - Otherwise hold.
- Forwarding outputs:
  - `fwd_valid` = `in_valid` & `in_reg_d_wen` & !`in_excp`.
  - `fwd_reg_d` = `in_reg_d`.
  - `fwd_data` = the WB data.
  - `fwd_stall` = `fwd_valid` & `in_mm_re` & !`ready_go`.

## Timing
- Reset (`rst`=1 at posedge):
  - state IDLE, `buf_data`=0.
  - `wb_valid`=0, `wb_excp`=0, `wb_reg_d`=0, `wb_reg_d_wen`=0, `wb_wdata`=0, `wb_pc`=0.
  - Combinational outputs then follow inputs.
- Reset mid-WAIT drops the pending response. The bus is reset together with the core.
- Latency:
  - `data_ok` in cycle N with `wb_allowin`=1 → `ready_go` in cycle N, `wb_*` valid in N+1.
  - Non-memory op: zero wait, `wb_*` in the cycle after entry.
- `data_ok` with `wb_allowin`=0: captured in GOT. Handoff happens the first cycle `wb_allowin`=1, with `rdata` then ignored.
- At most one outstanding response. A `data_ok` in GOT is a protocol error (no requirement).
- `flush` and `data_ok` in the same cycle in WAIT → IDLE, nothing captured, `wb_valid`←0.
- CANCEL blocks `mm2_allowin` until the stale `data_ok` arrives. The new MM2 instruction enters no earlier than the cycle after.

## Test plan
- ld.w, `in_addr_lo`=0, `data_ok` 3 cycles after entry, `rdata`=0x8badf00d, `wb_allowin`=1 → `fwd_stall`=1 for 3 cycles, `mm2_allowin`=0, then `wb_wdata`=0x8badf00d, `wb_valid`=1 next cycle.
- ld.b at `in_addr_lo`=3, `rdata`=0x80xxxxxx → `wb_wdata`=0xffffff80. ld.bu same → 0x00000080. ld.h at `in_addr_lo`=2, `rdata`=0x1234abcd → 0x00001234.
- `data_ok` with `wb_allowin`=0 for 2 cycles, `rdata` then changes to garbage → `wb_wdata` equals the captured value once `wb_allowin` rises.
- Flush in WAIT, then `data_ok` 2 cycles later → `wb_valid`=0, `mm2_allowin`=0 until `data_ok`, then 1. Stale data is never written.
- Store, `in_excp`=1, `rst` asserted mid-WAIT:
  - Store: `wb_reg_d_wen`=0 after `data_ok`.
  - `in_excp`=1: passes in 1 cycle with no `data_ok`, `wb_excp`=1, `wb_reg_d_wen`=0.
  - `rst` mid-WAIT: all `wb_*`=0, state IDLE.
